regfile_write_arbiter: RTL

Shares the single write port of the 32 x 64 register file between two writeback sources: the ALU result path (requester 0) and the memory-load path (requester 1). It arbitrates round-robin with a valid/ready handshake, registers the selected write onto the register file's `write`/`address`/`data_in` inputs, and keeps a 32-bit pending-write scoreboard that issue logic uses to stall readers of not-yet-written registers. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_write_arbiter_pkg.sv | 17 +
 rtl/regfile_write_arbiter_if.sv | 36 +++
 rtl/regfile_write_arbiter_rr_arbiter_2.sv | 47 ++++
 rtl/regfile_write_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write path: widths, the hardwired-zero
// register and the requester indices used by the write arbiter.
package regfile_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd31;

   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;

   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback request channels, the reserve port and the
// register-file write port seen by the write arbiter.
interface regfile_write_arbiter_if;
   import regfile_pkg::*;

   logic                hold;
   logic                alu_valid;
   reg_addr_t           alu_address;
   reg_data_t           alu_data;
   logic                alu_ready;
   logic                mem_valid;
   reg_addr_t           mem_address;
   reg_data_t           mem_data;
   logic                mem_ready;
   logic                reserve;
   reg_addr_t           reserve_address;
   logic                write;
   reg_addr_t           address;
   reg_data_t           data_in;
   logic [NUM_REGS-1:0] pending;

   modport master (
      output hold, alu_valid, alu_address, alu_data,
      output mem_valid, mem_address, mem_data,
      output reserve, reserve_address,
      input  alu_ready, mem_ready, write, address, data_in, pending
   );

   modport slave (
      input  hold, alu_valid, alu_address, alu_data,
      input  mem_valid, mem_address, mem_data,
      input  reserve, reserve_address,
      output alu_ready, mem_ready, write, address, data_in, pending
   );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter_2.sv
// Two-requester round-robin arbiter: one priority flip-flop, one-hot grant,
// no grants while hold or reset is high.
module rr_arbiter_2
   import regfile_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       hold,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   logic prio_r;
   logic [1:0] grant_s;

   // Grant selection; priority only matters when both requesters are valid.
   always_comb begin
      grant_s = 2'b00;
      if (reset || hold) begin
         grant_s = 2'b00;
      end else if (valid == 2'b11) begin
         if (prio_r == 1'(REQ_ALU)) begin
            grant_s[REQ_ALU] = 1'b1;
         end else begin
            grant_s[REQ_MEM] = 1'b1;
         end
      end else begin
         grant_s = valid;
      end
   end

   // Priority moves to the requester that did not win the last grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         prio_r <= 1'(REQ_ALU);
      end else if (grant_s[REQ_ALU]) begin
         prio_r <= 1'(REQ_MEM);
      end else if (grant_s[REQ_MEM]) begin
         prio_r <= 1'(REQ_ALU);
      end else begin
         prio_r <= prio_r;
      end
   end

   assign grant = grant_s;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback, registers
// the granted write and tracks outstanding destinations in a pending scoreboard.
module regfile_write_arbiter
   import regfile_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   regfile_write_arbiter_if.slave  bus
);

   logic [1:0]          valid_s;
   logic [1:0]          grant_s;
   reg_addr_t           win_address_s;
   reg_data_t           win_data_s;
   logic                write_r;
   reg_addr_t           address_r;
   reg_data_t           data_r;
   logic [NUM_REGS-1:0] pending_r;
   logic [NUM_REGS-1:0] pending_next_s;

   // Pack request valids by requester index.
   always_comb begin
      valid_s          = 2'b00;
      valid_s[REQ_ALU] = bus.alu_valid;
      valid_s[REQ_MEM] = bus.mem_valid;
   end

   rr_arbiter_2 u_arb (
      .clock (clock),
      .reset (reset),
      .hold  (bus.hold),
      .valid (valid_s),
      .grant (grant_s)
   );

   // Winner mux; grant is one-hot so defaulting to ALU is safe.
   always_comb begin
      win_address_s = bus.alu_address;
      win_data_s    = bus.alu_data;
      if (grant_s[REQ_MEM]) begin
         win_address_s = bus.mem_address;
         win_data_s    = bus.mem_data;
      end else begin
         win_address_s = bus.alu_address;
         win_data_s    = bus.alu_data;
      end
   end

   // Output stage: zero-register writes are accepted but never enable the port.
   always_ff @(posedge clock) begin
      if (reset) begin
         write_r   <= 1'b0;
         address_r <= '0;
         data_r    <= '0;
      end else if (grant_s != 2'b00) begin
         write_r   <= (win_address_s != ZERO_REG);
         address_r <= win_address_s;
         data_r    <= win_data_s;
      end else begin
         write_r   <= 1'b0;
         address_r <= address_r;
         data_r    <= data_r;
      end
   end

   // Scoreboard update: clear on write, then set on reserve so a same-index set wins.
   always_comb begin
      pending_next_s = pending_r;
      if (write_r) begin
         pending_next_s[address_r] = 1'b0;
      end else begin
         pending_next_s = pending_r;
      end
      if (bus.reserve) begin
         pending_next_s[bus.reserve_address] = 1'b1;
      end else begin
         pending_next_s = pending_next_s;
      end
      pending_next_s[ZERO_REG] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending_r <= '0;
      end else begin
         pending_r <= pending_next_s;
      end
   end

   assign bus.alu_ready = grant_s[REQ_ALU];
   assign bus.mem_ready = grant_s[REQ_MEM];
   assign bus.write     = write_r;
   assign bus.address   = address_r;
   assign bus.data_in   = data_r;
   assign bus.pending   = pending_r;

endmodule
